// File: rtl/first_nios2_system_char_tx.sv
// Avalon-MM slave UART transmitter (8N1, LSB first) with a programmable baud divisor.
// Ports:
//   clk, reset_n          - system clock, asynchronous active-low reset
//   address[1:0]          - 0 TXDATA, 1 STATUS {overrun,busy}, 2 DIVISOR, 3 reserved
//   chipselect, write_n   - write strobe (write when chipselect=1 and write_n=0)
//   writedata[31:0]       - write data
//   readdata[31:0]        - registered read data, one cycle latency
//   txd                   - serial output, idle high
//   char_sent             - one-cycle pulse on the first idle cycle after a frame
module first_nios2_system_char_tx #(
  parameter int unsigned DIV_DEFAULT = 434,
  parameter int unsigned DIV_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        txd,
  output logic        char_sent
);

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  localparam logic [1:0] ADDR_TXDATA  = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_DIVISOR = 2'd2;

  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(2);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DIV_DEFAULT);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(7);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e                state_q, state_d;
  logic [BYTE_W-1:0]     shift_q, shift_d;
  logic [BYTE_W-1:0]     last_byte_q, last_byte_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  frame_div_q, frame_div_d;
  logic [DIV_WIDTH-1:0]  baud_q, baud_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic                  overrun_q, overrun_d;
  logic                  txd_q, txd_d;
  logic                  char_sent_q, char_sent_d;
  logic [DATA_W-1:0]     readdata_q, readdata_d;

  logic                  wr;
  logic                  wr_txdata;
  logic                  wr_status;
  logic                  wr_divisor;
  logic                  busy;
  logic                  baud_done;
  logic [DIV_WIDTH-1:0]  wdiv;
  logic                  unused_wdata;

  assign wr         = chipselect & ~write_n;
  assign wr_txdata  = wr && (address == ADDR_TXDATA);
  assign wr_status  = wr && (address == ADDR_STATUS);
  assign wr_divisor = wr && (address == ADDR_DIVISOR);
  assign busy       = (state_q != S_IDLE);
  assign baud_done  = (baud_q == '0);
  assign wdiv       = writedata[DIV_WIDTH-1:0];
  assign unused_wdata = ^writedata[DATA_W-1:BYTE_W];

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and frame datapath; the divisor is sampled only when a frame starts
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    last_byte_d = last_byte_q;
    frame_div_d = frame_div_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    unique case (state_q)
      S_IDLE: begin
        if (wr_txdata) begin
          state_d     = S_START;
          shift_d     = writedata[BYTE_W-1:0];
          last_byte_d = writedata[BYTE_W-1:0];
          frame_div_d = div_q;
          baud_d      = div_q - DIV_ONE;
        end
      end
      S_START: begin
        if (baud_done) begin
          state_d = S_DATA;
          baud_d  = frame_div_q - DIV_ONE;
          bit_d   = '0;
        end else begin
          baud_d = baud_q - DIV_ONE;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = frame_div_q - DIV_ONE;
          if (bit_q == LAST_BIT) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + BIT_CNT_W'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          baud_d = baud_q - DIV_ONE;
        end
      end
      S_STOP: begin
        if (baud_done) begin
          state_d = S_IDLE;
          baud_d  = frame_div_q - DIV_ONE;
        end else begin
          baud_d = baud_q - DIV_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are derived from the next state so txd is registered yet aligned with the state
  always_comb begin
    txd_d       = 1'b1;
    char_sent_d = 1'b0;
    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
    if ((state_q == S_STOP) && (state_d == S_IDLE)) char_sent_d = 1'b1;
  end

  // Control registers; a dropped byte sets overrun ahead of any clear
  always_comb begin
    div_d = div_q;
    if (wr_divisor) div_d = (wdiv < DIV_MIN) ? DIV_MIN : wdiv;
    overrun_d = overrun_q;
    if (wr_status)         overrun_d = 1'b0;
    if (wr_txdata && busy) overrun_d = 1'b1;
  end

  // Read mux, sampled every cycle from pre-edge register values
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_TXDATA:  readdata_d = DATA_W'(last_byte_q);
      ADDR_STATUS:  readdata_d = DATA_W'({overrun_q, busy});
      ADDR_DIVISOR: readdata_d = DATA_W'(div_q);
      default:      readdata_d = '0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q     <= '0;
      last_byte_q <= '0;
      div_q       <= DIV_RST;
      frame_div_q <= DIV_RST;
      baud_q      <= '0;
      bit_q       <= '0;
      overrun_q   <= 1'b0;
      txd_q       <= 1'b1;
      char_sent_q <= 1'b0;
      readdata_q  <= '0;
    end else begin
      shift_q     <= shift_d;
      last_byte_q <= last_byte_d;
      div_q       <= div_d;
      frame_div_q <= frame_div_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      overrun_q   <= overrun_d;
      txd_q       <= txd_d;
      char_sent_q <= char_sent_d;
      readdata_q  <= readdata_d;
    end
  end

  assign readdata  = readdata_q;
  assign txd       = txd_q;
  assign char_sent = char_sent_q;

endmodule

// File: tb/tb_first_nios2_system_char_tx.sv
// Scoreboard bench for first_nios2_system_char_tx: stimulus queues expected reads and
// frames; one negedge monitor checks readdata, txd frames, char_sent and reset outputs.
module tb_first_nios2_system_char_tx;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [1:0]  address    = '0;
  logic        chipselect = 1'b0;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = '0;
  logic [31:0] readdata;
  logic        txd;
  logic        char_sent;

  first_nios2_system_char_tx #(.DIV_DEFAULT(434), .DIV_WIDTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .txd        (txd),
    .char_sent  (char_sent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    logic [1:0]  addr;
    int unsigned id;
  } rd_t;

  typedef struct {
    logic [7:0]  data;
    int unsigned div;
    int unsigned start;
  } fr_t;

  rd_t rd_q[$];
  fr_t fr_q[$];

  int unsigned ncyc   = 0;
  logic        rd_strobe = 1'b0;
  logic        rd_vld    = 1'b0;
  int unsigned rd_id  = 0;
  logic        done   = 1'b0;
  logic        fin    = 1'b0;
  int          n_vec  = 0;
  int          n_bad  = 0;

  // Cycle counter and read-response tag, both aligned with the DUT's rising edge
  always @(posedge clk) begin
    ncyc   <= ncyc + 1;
    rd_vld <= rd_strobe;
  end

  // Monitor state
  rd_t         rr;
  fr_t         cur;
  logic        in_frame = 1'b0;
  logic        cs_due   = 1'b0;
  logic        fr_bad   = 1'b0;
  logic        bad_got  = 1'b0;
  logic        bad_exp  = 1'b0;
  logic        exp_bit;
  int unsigned fcyc     = 0;
  int unsigned bad_at   = 0;
  int unsigned bi;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_frame = 1'b0;
      cs_due   = 1'b0;
      n_vec++;
      if (txd !== 1'b1 || char_sent !== 1'b0 || readdata !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_outputs: got txd=%b char_sent=%b readdata=%h, expected txd=1 char_sent=0 readdata=0",
                 txd, char_sent, readdata);
      end
    end else begin
      if (rd_vld) begin
        n_vec++;
        if (rd_q.size() == 0) begin
          n_bad++;
          $display("FAIL read_unexpected: got readdata=%h with no pending read", readdata);
        end else begin
          rr = rd_q.pop_front();
          if (readdata !== rr.exp) begin
            n_bad++;
            $display("FAIL read#%0d addr=%0d: got %h, expected %h", rr.id, rr.addr, readdata, rr.exp);
          end
        end
      end

      if (cs_due) begin
        cs_due = 1'b0;
        n_vec++;
        if (char_sent !== 1'b1) begin
          n_bad++;
          $display("FAIL char_sent_pulse at cycle %0d: got %b, expected 1", ncyc, char_sent);
        end
      end else if (char_sent !== 1'b0) begin
        n_vec++;
        n_bad++;
        $display("FAIL char_sent_spurious at cycle %0d: got %b, expected 0", ncyc, char_sent);
      end

      if (!in_frame && txd !== 1'b1) begin
        n_vec++;
        if (fr_q.size() == 0) begin
          n_bad++;
          $display("FAIL frame_unexpected at cycle %0d: got txd=%b, expected idle 1", ncyc, txd);
        end else begin
          cur      = fr_q.pop_front();
          in_frame = 1'b1;
          fcyc     = 0;
          fr_bad   = 1'b0;
          if (ncyc != cur.start) begin
            n_bad++;
            $display("FAIL frame_start byte=%h: got start cycle %0d, expected %0d", cur.data, ncyc, cur.start);
          end
        end
      end

      if (in_frame) begin
        bi = fcyc / cur.div;
        if (bi == 0)     exp_bit = 1'b0;
        else if (bi < 9) exp_bit = cur.data[bi-1];
        else             exp_bit = 1'b1;
        if (txd !== exp_bit && !fr_bad) begin
          fr_bad  = 1'b1;
          bad_at  = fcyc;
          bad_got = txd;
          bad_exp = exp_bit;
        end
        fcyc++;
        if (fcyc == 10 * cur.div) begin
          in_frame = 1'b0;
          cs_due   = 1'b1;
          n_vec++;
          if (fr_bad) begin
            n_bad++;
            $display("FAIL frame_bits byte=%h div=%0d: frame cycle %0d got txd=%b, expected %b",
                     cur.data, cur.div, bad_at, bad_got, bad_exp);
          end
        end
      end

      if (done && !fin) begin
        n_vec++;
        if (rd_q.size() != 0 || fr_q.size() != 0 || in_frame || cs_due) begin
          n_bad++;
          $display("FAIL drain: got pending reads=%0d frames=%0d in_frame=%b, expected all 0",
                   rd_q.size(), fr_q.size(), in_frame);
        end
        fin = 1'b1;
      end
    end
  end

  // Each bus task starts at a falling edge, spans one rising edge, and returns at the next falling edge
  task automatic bus_end();
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    rd_strobe  = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    bus_end();
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
    rd_t r;
    r.exp  = exp;
    r.addr = a;
    r.id   = rd_id;
    rd_id++;
    rd_q.push_back(r);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    rd_strobe  = 1'b1;
    bus_end();
  endtask

  task automatic send(input logic [7:0] b, input int unsigned div);
    fr_t f;
    f.data  = b;
    f.div   = div;
    f.start = ncyc + 1;
    fr_q.push_back(f);
    bus_write(2'd0, 32'(b));
  endtask

  task automatic till(input int unsigned k);
    while (ncyc < k) @(negedge clk);
  endtask

  int unsigned k0;

  initial begin
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    bus_read(2'd2, 32'd434);
    bus_read(2'd1, 32'd0);
    bus_read(2'd0, 32'd0);
    bus_read(2'd3, 32'd0);

    bus_write(2'd2, 32'd4);
    k0 = ncyc;
    send(8'h55, 4);                 // frame k0+1 .. k0+40, char_sent k0+41
    bus_read(2'd1, 32'd1);
    bus_write(2'd0, 32'h0000_00AA); // dropped, sets overrun
    bus_read(2'd1, 32'd3);
    bus_read(2'd0, 32'h55);
    bus_write(2'd2, 32'd8);         // applies from the next frame
    bus_read(2'd2, 32'd8);
    bus_read(2'd1, 32'd3);
    bus_write(2'd1, 32'd0);
    bus_read(2'd1, 32'd1);
    till(k0 + 20);
    bus_read(2'd1, 32'd1);
    till(k0 + 40);
    bus_read(2'd1, 32'd1);          // last stop-bit cycle is still busy

    send(8'h0F, 8);                 // char_sent cycle: frame k0+42 .. k0+121
    bus_read(2'd1, 32'd1);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, 32'd0);
    bus_read(2'd0, 32'h0F);
    bus_read(2'd2, 32'd8);
    till(k0 + 121);
    bus_write(2'd0, 32'h0000_0033); // write in last stop cycle is an overrun
    bus_read(2'd1, 32'd2);
    bus_write(2'd1, 32'd0);
    bus_read(2'd1, 32'd0);
    bus_read(2'd0, 32'h0F);

    bus_write(2'd2, 32'd1);
    bus_read(2'd2, 32'd2);
    bus_write(2'd2, 32'd0);
    bus_read(2'd2, 32'd2);
    send(8'hC3, 2);                 // frame k0+131 .. k0+150

    till(k0 + 152);
    bus_write(2'd2, 32'd4);
    send(8'hA5, 4);                 // frame from k0+154, bit 3 spans k0+170 .. k0+173
    till(k0 + 171);
    @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    bus_read(2'd1, 32'd0);
    bus_read(2'd2, 32'd434);
    bus_read(2'd0, 32'd0);
    repeat (60) @(negedge clk);

    done = 1'b1;
    wait (fin);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
